// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared types for the pipeline hazard controller: FSM state encoding,
//   forwarding-select codes, the shadow-pipeline entry and a match helper.
//   Shadow entries carry a fixed-width rd field (SHADOW_RD_W). Narrower
//   register addresses are zero-extended into it, so REG_AW must not exceed
//   SHADOW_RD_W.
package pipe_pkg;

  localparam int SHADOW_RD_W = 8;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hcu_state_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef struct packed {
    logic                   valid;
    logic [SHADOW_RD_W-1:0] rd;
    logic                   regwr;
    logic                   memrd;
  } shadow_entry_t;

  localparam shadow_entry_t SHADOW_EMPTY = {$bits(shadow_entry_t){1'b0}};

  // True when a used, non-zero source names the destination of a valid entry.
  function automatic logic src_hit(input shadow_entry_t          e,
                                   input logic [SHADOW_RD_W-1:0] src,
                                   input logic                   used);
    return used && (src != {SHADOW_RD_W{1'b0}}) && e.valid && (e.rd == src);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel
//   Forwarding-source selector for one source operand.
//   Ports:
//     src       - source register address from ID
//     src_used  - the instruction actually reads src
//     ex_entry / mem_entry / wb_entry - shadow pipeline entries
//     fwd       - 0=regfile, 1=EX, 2=MEM, 3=WB
module hazard_fwd_sel
  import pipe_pkg::*;
#(
  parameter int REG_AW = 3
) (
  input  logic [REG_AW-1:0] src,
  input  logic              src_used,
  input  shadow_entry_t     ex_entry,
  input  shadow_entry_t     mem_entry,
  input  shadow_entry_t     wb_entry,
  output logic [1:0]        fwd
);

  logic [SHADOW_RD_W-1:0] src_ext_s;

  assign src_ext_s = SHADOW_RD_W'(src);

  // Youngest register-writing producer wins; x0 and unused sources read the regfile.
  always_comb begin
    fwd = FWD_RF;
    if (src_hit(ex_entry, src_ext_s, src_used) && ex_entry.regwr) begin
      fwd = FWD_EX;
    end else if (src_hit(mem_entry, src_ext_s, src_used) && mem_entry.regwr) begin
      fwd = FWD_MEM;
    end else if (src_hit(wb_entry, src_ext_s, src_used) && wb_entry.regwr) begin
      fwd = FWD_WB;
    end else begin
      fwd = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Pipeline hazard controller: tracks EX/MEM/WB in a shadow pipeline,
//   selects forwarding paths, stalls on load-use, flushes after taken
//   branches and freezes the pipe while data memory is busy.
//   Ports:
//     clk, rst_n                 - clock, asynchronous active-low reset
//     id_valid                   - ID holds a real instruction
//     id_rs1/id_rs2, *_used      - ID sources and whether they are read
//     id_rd, id_regwr, id_memrd  - ID destination, writes-reg, is-load
//     br_taken                   - PC redirect resolved in ID this cycle
//     mem_busy                   - data memory not ready
//     fwd_a/fwd_b                - forwarding select per operand
//     stall_if_id, bubble_ex     - hold PC+IF/ID, inject NOP into ID/EX
//     flush_if_id                - kill IF/ID contents
//     freeze                     - hold every pipeline register
//     mem_timeout                - sticky memory-wait timeout
//   Control outputs are combinational: they must act in the same cycle as
//   the br_taken / mem_busy / hazard condition that causes them.
module hazard_ctrl_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW       = 3,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TMO      = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwr,
  input  logic              id_memrd,
  input  logic              br_taken,
  input  logic              mem_busy,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall_if_id,
  output logic              bubble_ex,
  output logic              flush_if_id,
  output logic              freeze,
  output logic              mem_timeout
);

  localparam int               WAIT_W       = $clog2(MEM_TMO + 1);
  localparam logic [1:0]       FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(MEM_TMO - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX    = WAIT_W'(MEM_TMO);

  shadow_entry_t     ex_r, mem_r, wb_r;
  shadow_entry_t     id_entry_s;
  hcu_state_e        state_r, saved_state_r;
  hcu_state_e        eff_state_s, next_state_s, next_saved_s;
  logic [1:0]        flush_cnt_r, next_cnt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              mem_timeout_r;

  logic [SHADOW_RD_W-1:0] rs1_ext_s, rs2_ext_s;
  logic              lu_ex_s, lu_mem_s, lu_wb_s, load_use_s;
  logic [1:0]        fwd_a_s, fwd_b_s;
  logic              freeze_s, flush_s, stall_s, bubble_s;

  assign rs1_ext_s  = SHADOW_RD_W'(id_rs1);
  assign rs2_ext_s  = SHADOW_RD_W'(id_rs2);
  assign id_entry_s = '{valid: id_valid, rd: SHADOW_RD_W'(id_rd),
                        regwr: id_regwr, memrd: id_memrd};

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .src      (id_rs1),
    .src_used (id_rs1_used),
    .ex_entry (ex_r),
    .mem_entry(mem_r),
    .wb_entry (wb_r),
    .fwd      (fwd_a_s)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .src      (id_rs2),
    .src_used (id_rs2_used),
    .ex_entry (ex_r),
    .mem_entry(mem_r),
    .wb_entry (wb_r),
    .fwd      (fwd_b_s)
  );

  // A load only blocks its consumer while it sits in the first LOAD_LAT stages.
  assign lu_ex_s  = ex_r.memrd  && (src_hit(ex_r,  rs1_ext_s, id_rs1_used) ||
                                    src_hit(ex_r,  rs2_ext_s, id_rs2_used));
  assign lu_mem_s = mem_r.memrd && (src_hit(mem_r, rs1_ext_s, id_rs1_used) ||
                                    src_hit(mem_r, rs2_ext_s, id_rs2_used));
  assign lu_wb_s  = wb_r.memrd  && (src_hit(wb_r,  rs1_ext_s, id_rs1_used) ||
                                    src_hit(wb_r,  rs2_ext_s, id_rs2_used));
  assign load_use_s = id_valid && (lu_ex_s ||
                                   ((LOAD_LAT >= 2) && lu_mem_s) ||
                                   ((LOAD_LAT >= 3) && lu_wb_s));

  // While waiting on memory, act as the interrupted state once mem_busy drops,
  // so the return costs no extra cycle.
  always_comb begin
    if (state_r == ST_MEM_WAIT) begin
      eff_state_s = saved_state_r;
    end else begin
      eff_state_s = state_r;
    end
  end

  // Next-state and control decode; priority mem_busy > br_taken > load-use.
  always_comb begin
    next_state_s = state_r;
    next_saved_s = saved_state_r;
    next_cnt_s   = flush_cnt_r;
    freeze_s     = 1'b0;
    flush_s      = 1'b0;
    stall_s      = 1'b0;
    bubble_s     = 1'b0;
    if (mem_busy) begin
      // Flush count is simply held, which preserves it across the wait.
      freeze_s     = 1'b1;
      next_state_s = ST_MEM_WAIT;
      next_saved_s = eff_state_s;
    end else begin
      case (eff_state_s)
        ST_RUN: begin
          if (br_taken) begin
            flush_s  = 1'b1;
            bubble_s = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              next_state_s = ST_FLUSH;
              next_cnt_s   = FLUSH_RELOAD;
            end else begin
              next_state_s = ST_RUN;
              next_cnt_s   = 2'd0;
            end
          end else if (load_use_s) begin
            stall_s      = 1'b1;
            bubble_s     = 1'b1;
            next_state_s = ST_RUN;
          end else begin
            next_state_s = ST_RUN;
          end
        end
        ST_FLUSH: begin
          flush_s  = 1'b1;
          bubble_s = 1'b1;
          if (br_taken) begin
            next_state_s = ST_FLUSH;
            next_cnt_s   = FLUSH_RELOAD;
          end else if (flush_cnt_r <= 2'd1) begin
            // Count reaches zero: this was the last bubble.
            next_state_s = ST_RUN;
            next_cnt_s   = 2'd0;
          end else begin
            next_state_s = ST_FLUSH;
            next_cnt_s   = flush_cnt_r - 2'd1;
          end
        end
        default: begin
          next_state_s = ST_RUN;
          next_cnt_s   = 2'd0;
        end
      endcase
    end
  end

  // FSM state, flush counter and return-state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_RUN;
      saved_state_r <= ST_RUN;
      flush_cnt_r   <= 2'd0;
    end else begin
      state_r       <= next_state_s;
      saved_state_r <= next_saved_s;
      flush_cnt_r   <= next_cnt_s;
    end
  end

  // Counts consecutive mem_busy cycles; the timeout flag is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r    <= {WAIT_W{1'b0}};
      mem_timeout_r <= 1'b0;
    end else if (mem_busy) begin
      if (wait_cnt_r != WAIT_MAX) begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end
      if (wait_cnt_r == WAIT_LAST) begin
        mem_timeout_r <= 1'b1;
      end
    end else begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end
  end

  // Shadow pipeline mirrors the datapath: shifts unless frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_r  <= SHADOW_EMPTY;
      mem_r <= SHADOW_EMPTY;
      wb_r  <= SHADOW_EMPTY;
    end else if (!freeze_s) begin
      wb_r  <= mem_r;
      mem_r <= ex_r;
      if (bubble_s || !id_valid) begin
        ex_r <= SHADOW_EMPTY;
      end else begin
        ex_r <= id_entry_s;
      end
    end
  end

  // Outputs are forced low during reset; mem_busy leaves only freeze active.
  assign freeze      = rst_n & freeze_s;
  assign flush_if_id = rst_n & flush_s;
  assign stall_if_id = rst_n & stall_s;
  assign bubble_ex   = rst_n & bubble_s;
  assign mem_timeout = rst_n & mem_timeout_r;
  assign fwd_a       = (rst_n && !mem_busy) ? fwd_a_s : FWD_RF;
  assign fwd_b       = (rst_n && !mem_busy) ? fwd_b_s : FWD_RF;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with LOAD_LAT=2, FLUSH_CYCLES=3, MEM_TMO=15.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge (or mid-cycle for purely combinational checks).
module tb_hazard_ctrl_unit;

  logic       clk, rst_n, id_valid, id_rs1_used, id_rs2_used, id_regwr, id_memrd;
  logic       br_taken, mem_busy;
  logic [2:0] id_rs1, id_rs2, id_rd;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_if_id, bubble_ex, flush_if_id, freeze, mem_timeout;
  logic [3:0] ctl;
  int         tests_run = 0;
  int         tests_failed = 0;

  // {freeze, flush_if_id, stall_if_id, bubble_ex}
  assign ctl = {freeze, flush_if_id, stall_if_id, bubble_ex};

  hazard_ctrl_unit #(.REG_AW(3), .LOAD_LAT(2), .FLUSH_CYCLES(3), .MEM_TMO(15)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwr(id_regwr), .id_memrd(id_memrd), .br_taken(br_taken), .mem_busy(mem_busy),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_if_id(stall_if_id), .bubble_ex(bubble_ex),
    .flush_if_id(flush_if_id), .freeze(freeze), .mem_timeout(mem_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic idle_inputs();
    id_valid = 1'b0; id_rs1 = 3'd0; id_rs2 = 3'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    id_rd = 3'd0; id_regwr = 1'b0; id_memrd = 1'b0; br_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (4) next_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs(); br_taken = 1'b1;
    #2;
    tests_run++;
    if (ctl !== 4'b0000) begin tests_failed++; $display("FAIL reset_ctl_br: got %b expected 0000", ctl); end
    br_taken = 1'b0; mem_busy = 1'b1;
    #2;
    tests_run++;
    if (ctl !== 4'b0000) begin tests_failed++; $display("FAIL reset_ctl_busy: got %b expected 0000", ctl); end
    mem_busy = 1'b0;
    #1;
    tests_run++;
    if ({fwd_a, fwd_b, mem_timeout} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_fwd_tmo: got %b expected 00000", {fwd_a, fwd_b, mem_timeout});
    end
    @(negedge clk); rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    tests_run++;
    if ({ctl, mem_timeout} !== 5'b0) begin
      tests_failed++; $display("FAIL post_reset_idle: got %b expected 00000", {ctl, mem_timeout});
    end
    next_cycle();
  endtask

  task automatic test_forward();
    idle_inputs(); id_valid = 1'b1; id_regwr = 1'b1; id_rd = 3'd3;
    next_cycle();                       // EX = rd3
    next_cycle();                       // EX = rd3, MEM = rd3
    id_regwr = 1'b0; id_rd = 3'd0; id_rs1 = 3'd3; id_rs1_used = 1'b1; id_rs2 = 3'd3;
    #2;
    tests_run++;
    if (fwd_a !== 2'd1) begin tests_failed++; $display("FAIL fwd_ex_priority: got %0d expected 1", fwd_a); end
    tests_run++;
    if (fwd_b !== 2'd0) begin tests_failed++; $display("FAIL fwd_unused_src: got %0d expected 0", fwd_b); end
    id_rs1 = 3'd0;
    #2;
    tests_run++;
    if (fwd_a !== 2'd0) begin tests_failed++; $display("FAIL fwd_x0: got %0d expected 0", fwd_a); end
    id_rs1 = 3'd3;
    next_cycle();                       // EX = non-writer, MEM = rd3, WB = rd3
    id_rs2_used = 1'b1;
    #2;
    tests_run++;
    if ({fwd_a, fwd_b} !== 4'b1010) begin
      tests_failed++; $display("FAIL fwd_mem: got %b expected 1010", {fwd_a, fwd_b});
    end
    id_valid = 1'b0;
    next_cycle();                       // MEM = non-writer, WB = rd3
    #2;
    tests_run++;
    if (fwd_a !== 2'd3) begin tests_failed++; $display("FAIL fwd_wb: got %0d expected 3", fwd_a); end
    next_cycle();                       // rd3 retired
    #2;
    tests_run++;
    if (fwd_a !== 2'd0) begin tests_failed++; $display("FAIL fwd_none: got %0d expected 0", fwd_a); end
    drain();
  endtask

  task automatic test_load_use();
    int stall_cnt;
    idle_inputs(); id_valid = 1'b1; id_rd = 3'd5; id_regwr = 1'b1; id_memrd = 1'b1;
    @(negedge clk);
    tests_run++;
    if (ctl !== 4'b0000) begin tests_failed++; $display("FAIL lu_load_issue: got %b expected 0000", ctl); end
    next_cycle();                       // load in EX
    id_rd = 3'd1; id_memrd = 1'b0; id_rs2 = 3'd5; id_rs2_used = 1'b1;
    stall_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (stall_if_id !== 1'b1) break;
      tests_run++;
      if (ctl !== 4'b0011) begin tests_failed++; $display("FAIL lu_stall_ctl: got %b expected 0011", ctl); end
      stall_cnt++;
      next_cycle();
    end
    tests_run++;
    if (stall_cnt !== 2) begin tests_failed++; $display("FAIL lu_stall_len: got %0d expected 2", stall_cnt); end
    tests_run++;
    if ({ctl, fwd_b} !== 6'b000011) begin
      tests_failed++; $display("FAIL lu_release_fwd_wb: got %b expected 000011", {ctl, fwd_b});
    end
    next_cycle();
    drain();
  endtask

  task automatic test_branch_over_load();
    idle_inputs(); id_valid = 1'b1; id_rd = 3'd5; id_regwr = 1'b1; id_memrd = 1'b1;
    next_cycle();                       // load in EX
    id_rd = 3'd0; id_regwr = 1'b0; id_memrd = 1'b0; id_rs1 = 3'd5; id_rs1_used = 1'b1;
    br_taken = 1'b1;
    @(negedge clk);
    tests_run++;
    if (ctl !== 4'b0101) begin tests_failed++; $display("FAIL br_over_lu: got %b expected 0101", ctl); end
    next_cycle();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (ctl !== ((i < 2) ? 4'b0101 : 4'b0000)) begin
        tests_failed++; $display("FAIL br_over_lu_tail[%0d]: got %b", i, ctl);
      end
      next_cycle();
    end
    drain();
  endtask

  task automatic test_flush();
    idle_inputs();
    for (int i = 0; i < 7; i++) begin
      br_taken = (i == 0);
      @(negedge clk);
      tests_run++;
      if (ctl !== ((i < 3) ? 4'b0101 : 4'b0000)) begin
        tests_failed++; $display("FAIL flush_single[%0d]: got %b", i, ctl);
      end
      next_cycle();
    end
    for (int i = 0; i < 7; i++) begin
      br_taken = (i < 2);
      @(negedge clk);
      tests_run++;
      if (ctl !== ((i < 4) ? 4'b0101 : 4'b0000)) begin
        tests_failed++; $display("FAIL flush_reload[%0d]: got %b", i, ctl);
      end
      next_cycle();
    end
    drain();
  endtask

  // Busy memory interrupts a flush with two bubbles still owed.
  task automatic test_freeze_in_flush();
    idle_inputs(); id_valid = 1'b1; id_regwr = 1'b1; id_rd = 3'd2;
    next_cycle();                       // EX = rd2
    idle_inputs(); br_taken = 1'b1;
    @(negedge clk);
    tests_run++;
    if (ctl !== 4'b0101) begin tests_failed++; $display("FAIL frz_br: got %b expected 0101", ctl); end
    next_cycle();                       // MEM = rd2, FLUSH with 2 owed
    br_taken = 1'b0; mem_busy = 1'b1; id_rs1 = 3'd2; id_rs1_used = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if ({ctl, fwd_a} !== 6'b100000) begin
        tests_failed++; $display("FAIL frz_hold[%0d]: got %b expected 100000", i, {ctl, fwd_a});
      end
      next_cycle();
    end
    mem_busy = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({ctl, fwd_a} !== 6'b010110) begin
      tests_failed++; $display("FAIL frz_resume1: got %b expected 010110", {ctl, fwd_a});
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if ({ctl, fwd_a} !== 6'b010111) begin
      tests_failed++; $display("FAIL frz_resume2: got %b expected 010111", {ctl, fwd_a});
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (ctl !== 4'b0000) begin tests_failed++; $display("FAIL frz_done: got %b expected 0000", ctl); end
    next_cycle();
    drain();
  endtask

  task automatic test_timeout();
    idle_inputs(); mem_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests_run++;
      if ({freeze, mem_timeout} !== {1'b1, (i >= 15)}) begin
        tests_failed++; $display("FAIL tmo_busy[%0d]: got %b", i, {freeze, mem_timeout});
      end
      next_cycle();
    end
    mem_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if ({freeze, mem_timeout} !== 2'b01) begin
        tests_failed++; $display("FAIL tmo_sticky[%0d]: got %b expected 01", i, {freeze, mem_timeout});
      end
      next_cycle();
    end
    rst_n = 1'b0;
    #2;
    tests_run++;
    if (mem_timeout !== 1'b0) begin tests_failed++; $display("FAIL tmo_in_reset: got %b expected 0", mem_timeout); end
    @(negedge clk); rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (mem_timeout !== 1'b0) begin tests_failed++; $display("FAIL tmo_cleared: got %b expected 0", mem_timeout); end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    idle_inputs(); br_taken = 1'b1;
    next_cycle();                       // FLUSH
    br_taken = 1'b0; mem_busy = 1'b1;
    next_cycle();
    next_cycle();                       // MEM_WAIT, return state FLUSH
    @(negedge clk);
    tests_run++;
    if (ctl !== 4'b1000) begin tests_failed++; $display("FAIL rmw_waiting: got %b expected 1000", ctl); end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({ctl, fwd_a, fwd_b, mem_timeout} !== 9'b0) begin
      tests_failed++; $display("FAIL rmw_outputs_low: got %b expected 0", {ctl, fwd_a, fwd_b, mem_timeout});
    end
    mem_busy = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++;
      if (ctl !== 4'b0000) begin tests_failed++; $display("FAIL rmw_run[%0d]: got %b expected 0000", i, ctl); end
      next_cycle();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    test_reset();
    test_forward();
    test_load_use();
    test_branch_over_load();
    test_flush();
    test_freeze_in_flush();
    test_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
